gpio_pad_ctrl: RTL and testbench
================================

# gpio_pad_ctrl

GPIO bank controller that sits directly upstream/downstream of the bidirectional pad ring. It drives each tri-state pad's output data and output enable, and synchronises each pad's input value back into the core clock domain. It detects rising and falling input edges into a sticky, write-1-to-clear interrupt status register, and exposes everything through a simple valid/ready register port on the SoC peripheral bus.

## Interface

**Parameters**
- `GPIO_NUM`, default 16: number of pads in the bank, 1..32. Register bits at and above `GPIO_NUM` read 0 and ignore writes.

**Ports**
- `clk_i`, input, 1: core clock. Single clock domain.
- `rst_i`, input, 1: reset. Synchronous, active-high.
- `reg_valid_i`, input, 1: register access request. Held high until `reg_ready_o`.
- `reg_we_i`, input, 1: 1 = write, 0 = read. Stable while `reg_valid_i` is high.
- `reg_addr_i`, input, 5: byte address. Decode uses `[4:2]`; `[1:0]` is ignored.
- `reg_wdata_i`, input, 32: write data.
- `reg_rdata_o`, output, 32: read data. Valid in the cycle `reg_ready_o`=1; 0 otherwise.
- `reg_ready_o`, output, 1: one-cycle completion pulse.
- `gpio_out_o`, output, `GPIO_NUM`: drives each pad's c2p.
- `gpio_oe_o`, output, `GPIO_NUM`: drives each pad's c2p_en; 1 = driving.
- `gpio_in_i`, input, `GPIO_NUM`: from each pad's p2c. Asynchronous to `clk_i`.
- `irq_o`, output, 1: level interrupt, equal to OR of `IRQ_STAT`.

## Operation

**Register map (`addr[4:2]`)**
- 0 `OUT`: RW. Drives `gpio_out_o`.
- 1 `OE`: RW. Drives `gpio_oe_o`.
- 2 `IN`: RO. Synchronised pad value.
- 3 `RISE_EN`: RW. Per-pin rising-edge interrupt enable.
- 4 `FALL_EN`: RW. Per-pin falling-edge interrupt enable.
- 5 `IRQ_STAT`: W1C. A write of 1 clears that bit; a write of 0 has no effect.
- 6 `OUT_TGL`: WO. Each 1 bit inverts the matching `OUT` bit. Reads return 0.
- 7: reserved. Reads 0; writes are ignored.

**Input path**
- Per pin: `sync1` then `sync2` (2-flop synchroniser), then `prev` (holds last `sync2`).
- `IN` = `sync2`.
- `rise` = `sync2 & ~prev`; `fall` = `~sync2 & prev`.
- Every clock: `IRQ_STAT` |= (`rise` & `RISE_EN`) | (`fall` & `FALL_EN`).

**Arm counter**
- 2-bit `arm` counter, 0 after reset, increments to 3 and saturates there.
- Edge detection is suppressed while `arm` < 3. This means a pad that is already high at reset release does not raise a rising-edge interrupt.

**Bus FSM (states IDLE, RESP)**
- IDLE, `reg_valid_i`=1: at that clock edge, perform the write or capture the read data, then go to RESP.
- RESP: `reg_ready_o`=1 for exactly one cycle, then go to IDLE. `reg_valid_i` seen in RESP is not a new request.
- Maximum throughput: one access every 2 cycles.

**Simultaneous events**
- W1C clear and a new edge on the same bit in the same cycle: the set wins, and the bit stays 1.
- Writing an enable register does not set or clear any `IRQ_STAT` bit. An enable disables only future captures.
- `OUT` write and `OUT_TGL` never coincide, because one access is in flight at a time.

## Timing

**Reset values** (all are 0)
- `OUT`, `OE`, `RISE_EN`, `FALL_EN`, `IRQ_STAT`, `sync1`, `sync2`, `prev`, `arm`.
- Outputs: `gpio_out_o`=0, `gpio_oe_o`=0 (all pads high-Z), `irq_o`=0, `reg_ready_o`=0, `reg_rdata_o`=0.
- FSM returns to IDLE.

**Reset mid-transaction**
- `rst_i` during RESP aborts the access: `reg_ready_o` is 0 in the next cycle.
- A write accepted at the edge where `rst_i`=1 is discarded, because reset has priority.

**Latencies**
- Request to `reg_ready_o`: 1 cycle. Valid is sampled at edge N; ready is high during cycle N+1.
- Write to pad: `gpio_out_o`/`gpio_oe_o` update at the accepting edge, visible in the following cycle.
- Pad to `IN`: a `gpio_in_i` change captured at edge E is readable in `IN` after edge E+1.
- Pad to interrupt: `IRQ_STAT` bit set at edge E+2; `irq_o` high after edge E+2. `irq_o` is combinational from `IRQ_STAT`.
- W1C: the bit clears at the accepting edge; `irq_o` falls in the next cycle if no other bits are set.

**Pulse width**
- Input pulses shorter than one clock period may be missed. This is not an error condition.

## Test plan

1. **Reset and defaults.** Assert `rst_i` 2 cycles with `gpio_in_i`=all 1 and both enables then set to all 1. Required: all outputs 0, `IRQ_STAT`=0 (arm suppression), `IN`=0xFFFF (`GPIO_NUM`=16).
2. **Output path.** Write `OE`=0x00FF, `OUT`=0xA5A5, then `OUT_TGL`=0x000F. Required: `gpio_oe_o`=0x00FF; `gpio_out_o`=0xA5AA; each `reg_ready_o` pulse exactly 1 cycle after valid; read of `OUT_TGL` = 0.
3. **Edge interrupts.** `RISE_EN`=0x0001, `FALL_EN`=0x0002; raise pin 0, drop pin 1 (previously high), toggle pin 2. Required: `IRQ_STAT`=0x0003 exactly 3 edges after the pin change; `irq_o`=1; pin 2 not captured.
4. **W1C plus same-cycle edge.** `IRQ_STAT`=0x0003; write 0x0001 timed so that a new pin 0 rising edge lands on the write edge. Required: `IRQ_STAT` stays 0x0003. Repeat without the edge: `IRQ_STAT`=0x0002. Write 0x0002: `irq_o`=0 one cycle later.
5. **Boundary bits.** With `GPIO_NUM`=16: write 0xFFFFFFFF to `OUT`, then read back. Required: read = 0x0000FFFF. Address 7 reads 0. `reg_addr_i[1:0]`=3 decodes the same as 0.
6. **Reset mid-access.** Assert `rst_i` in the RESP cycle of a write to `OE`=0xFFFF. Required: `reg_ready_o`=0 next cycle; `gpio_oe_o`=0.

Source files
------------

// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pad_ctrl
// Brief    : GPIO bank controller placed next to the bidirectional pad ring.
//            It drives pad output data and output enables, synchronises pad
//            inputs into the core clock domain, and captures rising/falling
//            edges into a sticky write-1-to-clear interrupt status register.
//            All of this is reached through a valid/ready register port.
//
// Ports    : clk_i        core clock (single clock domain)
//            rst_i        synchronous active-high reset
//            reg_valid_i  access request, held until reg_ready_o
//            reg_we_i     1 = write, 0 = read
//            reg_addr_i   byte address; [4:2] selects the register
//            reg_wdata_i  write data
//            reg_rdata_o  read data, non-zero only while reg_ready_o = 1
//            reg_ready_o  one-cycle completion pulse
//            gpio_out_o   pad output data (c2p)
//            gpio_oe_o    pad output enable (c2p_en), 1 = driving
//            gpio_in_i    pad input value (p2c), asynchronous to clk_i
//            irq_o        level interrupt, OR of all IRQ_STAT bits
//
// Register map (reg_addr_i[4:2]):
//            0 OUT      RW     1 OE       RW     2 IN      RO
//            3 RISE_EN  RW     4 FALL_EN  RW     5 IRQ_STAT W1C
//            6 OUT_TGL  WO (reads 0)             7 reserved (reads 0)
//
// Revision : 1.0  initial release
// ============================================================================
module gpio_pad_ctrl #(
    parameter int GPIO_NUM = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                reg_valid_i,
    input  logic                reg_we_i,
    input  logic [4:0]          reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    output logic [31:0]         reg_rdata_o,
    output logic                reg_ready_o,

    output logic [GPIO_NUM-1:0] gpio_out_o,
    output logic [GPIO_NUM-1:0] gpio_oe_o,
    input  logic [GPIO_NUM-1:0] gpio_in_i,

    output logic                irq_o
);

    // ------------------------------------------------------------------------
    // Register selects
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ADDR_OUT     = 3'd0;
    localparam logic [2:0] c_ADDR_OE      = 3'd1;
    localparam logic [2:0] c_ADDR_IN      = 3'd2;
    localparam logic [2:0] c_ADDR_RISE_EN = 3'd3;
    localparam logic [2:0] c_ADDR_FALL_EN = 3'd4;
    localparam logic [2:0] c_ADDR_STAT    = 3'd5;
    localparam logic [2:0] c_ADDR_TGL     = 3'd6;

    localparam logic [1:0] c_ARM_DONE     = 2'd3;

    // ------------------------------------------------------------------------
    // Bus FSM state encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [GPIO_NUM-1:0]   r_out;
    logic [GPIO_NUM-1:0]   r_oe;
    logic [GPIO_NUM-1:0]   r_rise_en;
    logic [GPIO_NUM-1:0]   r_fall_en;
    logic [GPIO_NUM-1:0]   r_irq_stat;
    logic [GPIO_NUM-1:0]   r_sync1;
    logic [GPIO_NUM-1:0]   r_sync2;
    logic [GPIO_NUM-1:0]   r_prev;
    logic [1:0]            r_arm;
    logic [31:0]           r_rdata;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                  w_accept;
    logic                  w_wr;
    logic                  w_rd;
    logic [2:0]            w_sel;
    logic [GPIO_NUM-1:0]   w_wdata;
    logic [31:0]           w_rd_mux;
    logic                  w_armed;
    logic [GPIO_NUM-1:0]   w_rise;
    logic [GPIO_NUM-1:0]   w_fall;
    logic [GPIO_NUM-1:0]   w_set;
    logic [GPIO_NUM-1:0]   w_clr;
    logic                  w_unused;

    // Byte-lane bits of the address and write-data bits above the bank width
    // carry no meaning; fold them into one sink so they are visibly consumed.
    assign w_unused = ^{reg_addr_i[1:0], reg_wdata_i};

    // A request is only taken in IDLE; a valid still high during RESP is the
    // tail of the access being completed, not a new one.
    assign w_accept = (r_state == ST_IDLE) && reg_valid_i;
    assign w_wr     = w_accept &&  reg_we_i;
    assign w_rd     = w_accept && !reg_we_i;
    assign w_sel    = reg_addr_i[4:2];
    assign w_wdata  = reg_wdata_i[GPIO_NUM-1:0];

    // ------------------------------------------------------------------------
    // Bus FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Bus FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        reg_ready_o = 1'b0;
        reg_rdata_o = 32'h0000_0000;
        case (r_state)
            ST_IDLE: begin
                if (reg_valid_i) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                reg_ready_o = 1'b1;
                reg_rdata_o = r_rdata;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Read data mux (bits at and above GPIO_NUM stay 0)
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_mux = 32'h0000_0000;
        case (w_sel)
            c_ADDR_OUT:     w_rd_mux[GPIO_NUM-1:0] = r_out;
            c_ADDR_OE:      w_rd_mux[GPIO_NUM-1:0] = r_oe;
            c_ADDR_IN:      w_rd_mux[GPIO_NUM-1:0] = r_sync2;
            c_ADDR_RISE_EN: w_rd_mux[GPIO_NUM-1:0] = r_rise_en;
            c_ADDR_FALL_EN: w_rd_mux[GPIO_NUM-1:0] = r_fall_en;
            c_ADDR_STAT:    w_rd_mux[GPIO_NUM-1:0] = r_irq_stat;
            default:        w_rd_mux = 32'h0000_0000;
        endcase
    end

    // Read data is captured at the accepting edge so it reflects the state the
    // request saw, and is presented during the RESP cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= 32'h0000_0000;
        end else if (w_rd) begin
            r_rdata <= w_rd_mux;
        end else if (w_accept) begin
            r_rdata <= 32'h0000_0000;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out <= '0;
        end else if (w_wr && (w_sel == c_ADDR_OUT)) begin
            r_out <= w_wdata;
        end else if (w_wr && (w_sel == c_ADDR_TGL)) begin
            r_out <= r_out ^ w_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_oe      <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            if (w_sel == c_ADDR_OE) begin
                r_oe <= w_wdata;
            end
            if (w_sel == c_ADDR_RISE_EN) begin
                r_rise_en <= w_wdata;
            end
            if (w_sel == c_ADDR_FALL_EN) begin
                r_fall_en <= w_wdata;
            end
        end
    end

    assign gpio_out_o = r_out;
    assign gpio_oe_o  = r_oe;

    // ------------------------------------------------------------------------
    // Input path: two-flop synchroniser plus one history stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= gpio_in_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // The pipeline restarts from 0 after reset, so a pad already high would
    // look like a rising edge. Edge capture is held off until the arm counter
    // saturates, by which time prev holds a genuine sample of the pad.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_arm <= 2'd0;
        end else if (r_arm != c_ARM_DONE) begin
            r_arm <= r_arm + 2'd1;
        end
    end

    assign w_armed = (r_arm == c_ARM_DONE);
    assign w_rise  = r_sync2 & ~r_prev;
    assign w_fall  = ~r_sync2 & r_prev;
    assign w_set   = w_armed ? ((w_rise & r_rise_en) | (w_fall & r_fall_en))
                             : '0;
    assign w_clr   = (w_wr && (w_sel == c_ADDR_STAT)) ? w_wdata : '0;

    // ------------------------------------------------------------------------
    // Interrupt status: the set term is applied after the clear, so an edge
    // arriving on the same cycle as a W1C keeps the bit set.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq_stat <= '0;
        end else begin
            r_irq_stat <= (r_irq_stat & ~w_clr) | w_set;
        end
    end

    assign irq_o = |r_irq_stat;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_pad_ctrl
// Brief    : Self-checking bench for gpio_pad_ctrl (GPIO_NUM = 16). Register
//            traffic is applied from a table of {access, expected} records;
//            interrupt timing, W1C collisions and reset mid-access are covered
//            by short hand-written sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_gpio_pad_ctrl;

    localparam int GPIO_NUM = 16;

    localparam logic [4:0] A_OUT  = 5'h00;
    localparam logic [4:0] A_OE   = 5'h04;
    localparam logic [4:0] A_IN   = 5'h08;
    localparam logic [4:0] A_REN  = 5'h0C;
    localparam logic [4:0] A_FEN  = 5'h10;
    localparam logic [4:0] A_STAT = 5'h14;
    localparam logic [4:0] A_TGL  = 5'h18;
    localparam logic [4:0] A_RSV  = 5'h1C;

    logic                clk = 1'b0;
    logic                rst;
    logic                reg_valid;
    logic                reg_we;
    logic [4:0]          reg_addr;
    logic [31:0]         reg_wdata;
    logic [31:0]         reg_rdata;
    logic                reg_ready;
    logic [GPIO_NUM-1:0] gpio_out;
    logic [GPIO_NUM-1:0] gpio_oe;
    logic [GPIO_NUM-1:0] gpio_in;
    logic                irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gpio_pad_ctrl #(
        .GPIO_NUM (GPIO_NUM)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .reg_valid_i (reg_valid),
        .reg_we_i    (reg_we),
        .reg_addr_i  (reg_addr),
        .reg_wdata_i (reg_wdata),
        .reg_rdata_o (reg_rdata),
        .reg_ready_o (reg_ready),
        .gpio_out_o  (gpio_out),
        .gpio_oe_o   (gpio_oe),
        .gpio_in_i   (gpio_in),
        .irq_o       (irq)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        chk_pins;
        logic [15:0] exp_out;
        logic [15:0] exp_oe;
        string       name;
    } vec_t;

    localparam int N_VEC = 13;
    vec_t vecs [N_VEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One register access. Valid is raised mid-cycle, sampled at the next
    // rising edge, and ready must be high exactly in the following cycle.
    task automatic bus(input logic we, input logic [4:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata);
        @(negedge clk);
        reg_valid = 1'b1;
        reg_we    = we;
        reg_addr  = addr;
        reg_wdata = wdata;
        @(posedge clk);
        #1;
        chk("ready_latency", 32'(reg_ready), 32'h1);
        rdata     = reg_rdata;
        reg_valid = 1'b0;
        reg_we    = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_width", 32'(reg_ready), 32'h0);
    endtask

    logic [31:0] rd;

    initial begin
        // Output path, boundary bits and address decode.
        vecs[0]  = '{1'b1, A_OE,   32'h0000_00FF, 1'b0, 32'h0, 1'b1, 16'h0000, 16'h00FF, "wr_oe"};
        vecs[1]  = '{1'b1, A_OUT,  32'h0000_A5A5, 1'b0, 32'h0, 1'b1, 16'hA5A5, 16'h00FF, "wr_out"};
        vecs[2]  = '{1'b1, A_TGL,  32'h0000_000F, 1'b0, 32'h0, 1'b1, 16'hA5AA, 16'h00FF, "wr_tgl"};
        vecs[3]  = '{1'b0, A_TGL,  32'h0,         1'b1, 32'h0, 1'b0, 16'h0000, 16'h0000, "rd_tgl"};
        vecs[4]  = '{1'b0, A_OUT,  32'h0,         1'b1, 32'h0000_A5AA, 1'b0, 16'h0, 16'h0, "rd_out"};
        vecs[5]  = '{1'b0, A_OE,   32'h0,         1'b1, 32'h0000_00FF, 1'b0, 16'h0, 16'h0, "rd_oe"};
        vecs[6]  = '{1'b1, A_OUT,  32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 16'hFFFF, 16'h00FF, "wr_out_all"};
        vecs[7]  = '{1'b0, A_OUT,  32'h0,         1'b1, 32'h0000_FFFF, 1'b0, 16'h0, 16'h0, "rd_out_mask"};
        vecs[8]  = '{1'b0, A_RSV,  32'h0,         1'b1, 32'h0, 1'b0, 16'h0, 16'h0, "rd_rsv"};
        vecs[9]  = '{1'b1, A_RSV,  32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 16'hFFFF, 16'h00FF, "wr_rsv"};
        vecs[10] = '{1'b1, 5'h03,  32'h0000_1234, 1'b0, 32'h0, 1'b1, 16'h1234, 16'h00FF, "wr_out_a3"};
        vecs[11] = '{1'b0, A_OUT,  32'h0,         1'b1, 32'h0000_1234, 1'b0, 16'h0, 16'h0, "rd_out_a0"};
        vecs[12] = '{1'b0, 5'h07,  32'h0,         1'b1, 32'h0000_00FF, 1'b0, 16'h0, 16'h0, "rd_oe_a7"};

        rst       = 1'b1;
        reg_valid = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = 5'h0;
        reg_wdata = 32'h0;
        gpio_in   = 16'hFFFF;

        // ---- Reset and defaults ------------------------------------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out",   32'(gpio_out),  32'h0);
        chk("rst_oe",    32'(gpio_oe),   32'h0);
        chk("rst_irq",   32'(irq),       32'h0);
        chk("rst_ready", 32'(reg_ready), 32'h0);
        chk("rst_rdata", reg_rdata,      32'h0);
        rst = 1'b0;

        bus(1'b1, A_REN, 32'h0000_FFFF, rd);
        bus(1'b1, A_FEN, 32'h0000_FFFF, rd);
        repeat (4) @(posedge clk);
        #1;
        chk("arm_irq", 32'(irq), 32'h0);
        bus(1'b0, A_STAT, 32'h0, rd);
        chk("arm_stat", rd, 32'h0);
        bus(1'b0, A_IN, 32'h0, rd);
        chk("in_all_high", rd, 32'h0000_FFFF);
        chk("idle_rdata", reg_rdata, 32'h0);

        // ---- Table-driven register accesses -------------------------------
        for (int i = 0; i < N_VEC; i++) begin
            bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            if (vecs[i].chk_rd) begin
                chk(vecs[i].name, rd, vecs[i].exp_rd);
            end
            if (vecs[i].chk_pins) begin
                chk({vecs[i].name, "_pin_out"}, 32'(gpio_out), 32'(vecs[i].exp_out));
                chk({vecs[i].name, "_pin_oe"},  32'(gpio_oe),  32'(vecs[i].exp_oe));
            end
        end

        // ---- Edge interrupts ---------------------------------------------
        bus(1'b1, A_REN, 32'h0, rd);
        bus(1'b1, A_FEN, 32'h0, rd);
        @(negedge clk);
        gpio_in = 16'h0002;
        repeat (4) @(posedge clk);
        bus(1'b1, A_REN, 32'h0000_0001, rd);
        bus(1'b1, A_FEN, 32'h0000_0002, rd);
        bus(1'b0, A_STAT, 32'h0, rd);
        chk("edge_pre_stat", rd, 32'h0);
        bus(1'b0, A_IN, 32'h0, rd);
        chk("edge_pre_in", rd, 32'h0000_0002);

        @(negedge clk);
        gpio_in = 16'h0005;
        @(posedge clk); #1;
        chk("edge_irq_e1", 32'(irq), 32'h0);
        @(posedge clk); #1;
        chk("edge_irq_e2", 32'(irq), 32'h0);
        @(posedge clk); #1;
        chk("edge_irq_e3", 32'(irq), 32'h1);
        bus(1'b0, A_STAT, 32'h0, rd);
        chk("edge_stat", rd, 32'h0000_0003);
        @(negedge clk);
        gpio_in = 16'h0001;
        repeat (4) @(posedge clk);
        bus(1'b0, A_STAT, 32'h0, rd);
        chk("edge_pin2_ignored", rd, 32'h0000_0003);

        // ---- W1C colliding with a new edge --------------------------------
        @(negedge clk);
        gpio_in = 16'h0000;
        repeat (4) @(posedge clk);
        @(negedge clk);
        gpio_in = 16'h0001;
        @(posedge clk);
        @(posedge clk);
        // Accepting edge of this write is the third edge after the change.
        bus(1'b1, A_STAT, 32'h0000_0001, rd);
        bus(1'b0, A_STAT, 32'h0, rd);
        chk("w1c_collide", rd, 32'h0000_0003);
        bus(1'b1, A_STAT, 32'h0000_0000, rd);
        bus(1'b0, A_STAT, 32'h0, rd);
        chk("w1c_zero_noop", rd, 32'h0000_0003);
        bus(1'b1, A_STAT, 32'h0000_0001, rd);
        bus(1'b0, A_STAT, 32'h0, rd);
        chk("w1c_clear0", rd, 32'h0000_0002);
        chk("w1c_irq_still", 32'(irq), 32'h1);
        bus(1'b1, A_STAT, 32'h0000_0002, rd);
        chk("w1c_irq_low", 32'(irq), 32'h0);

        // ---- Reset during RESP of a write --------------------------------
        @(negedge clk);
        reg_valid = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = A_OE;
        reg_wdata = 32'h0000_FFFF;
        @(posedge clk); #1;
        chk("rstmid_ready", 32'(reg_ready), 32'h1);
        chk("rstmid_oe_set", 32'(gpio_oe), 32'h0000_FFFF);
        rst       = 1'b1;
        reg_valid = 1'b0;
        reg_we    = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_ready_drop", 32'(reg_ready), 32'h0);
        chk("rstmid_oe", 32'(gpio_oe), 32'h0);
        chk("rstmid_out", 32'(gpio_out), 32'h0);
        rst = 1'b0;
        bus(1'b0, A_OE, 32'h0, rd);
        chk("rstmid_rd_oe", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
